// File: rtl/lsu_mem_ctrl_pkg.sv
// rtl/lsu_mem_ctrl_pkg.sv - shared access-size codes, FSM states and bus width for the load/store unit
package lsu_mem_ctrl_pkg;

    localparam int BUS_AW = 30;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ0,
        ST_WAIT0,
        ST_REQ1,
        ST_WAIT1,
        ST_DONE
    } state_t;

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-mask generation, store lane shift and load extract/extend
module lsu_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [2:0]  size,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic [63:0] load_buf,
    output logic        legal,
    output logic [7:0]  mask,
    output logic [63:0] store_lanes,
    output logic [31:0] load_data
);

    logic [3:0]  base_mask;
    logic [63:0] shifted;

    always_comb begin
        legal     = 1'b1;
        base_mask = 4'h0;
        case (size)
            MEM_B, MEM_BU: base_mask = 4'h1;
            MEM_H, MEM_HU: base_mask = 4'h3;
            MEM_W:         base_mask = 4'hF;
            default:       legal     = 1'b0;
        endcase
    end

    // Two-word view: the upper half belongs to the second beat of a split access.
    assign mask        = {4'h0, base_mask} << offset;
    assign store_lanes = {32'h0, store_data} << {offset, 3'b000};
    assign shifted     = load_buf >> {offset, 3'b000};

    always_comb begin
        load_data = 32'h0;
        case (size)
            MEM_B:   load_data = {{24{shifted[7]}}, shifted[7:0]};
            MEM_BU:  load_data = {24'h0, shifted[7:0]};
            MEM_H:   load_data = {{16{shifted[15]}}, shifted[15:0]};
            MEM_HU:  load_data = {16'h0, shifted[15:0]};
            MEM_W:   load_data = shifted[31:0];
            default: load_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// rtl/lsu_mem_ctrl.sv - M-stage load/store controller driving a handshaked word bus
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter bit ALLOW_MISALIGNED = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memreadM,
    input  logic              memwriteM,
    input  logic [31:0]       aluoutM,
    input  logic [31:0]       writedataM,
    input  logic [2:0]        memsizeM,
    output logic [31:0]       readdataM,
    output logic              stallM,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [BUS_AW-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [31:0]       bus_wdata,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q;
    logic [2:0]  size_q;
    logic        we_q, err_q;
    logic [63:0] buf_q;

    logic        idle, access, legal, crosses, bad;
    logic [2:0]  size_sel;
    logic [1:0]  off_sel;
    logic [7:0]  mask;
    logic [63:0] store_lanes;
    logic [31:0] load_data;

    assign idle   = (state == ST_IDLE);
    assign access = memreadM | memwriteM;

    // Live inputs are only needed to classify the access in IDLE; afterwards the latched copy rules.
    assign size_sel = idle ? memsizeM : size_q;
    assign off_sel  = idle ? aluoutM[1:0] : addr_q[1:0];

    lsu_lane_align u_align (
        .size        (size_sel),
        .offset      (off_sel),
        .store_data  (wdata_q),
        .load_buf    (buf_q),
        .legal       (legal),
        .mask        (mask),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    assign crosses = |mask[7:4];
    assign bad     = !legal || (crosses && !ALLOW_MISALIGNED);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'h0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            buf_q   <= 64'h0;
        end else begin
            if (idle && access) begin
                addr_q  <= aluoutM;
                wdata_q <= writedataM;
                size_q  <= memsizeM;
                we_q    <= memwriteM;
                err_q   <= bad;
                buf_q   <= 64'h0;
            end
            if (state == ST_WAIT0 && bus_rvalid) buf_q[31:0]  <= bus_rdata;
            if (state == ST_WAIT1 && bus_rvalid) buf_q[63:32] <= bus_rdata;
        end
    end

    always_comb begin
        state_next = state;
        stallM     = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        readdataM  = 32'h0;
        bus_req    = 1'b0;
        bus_we     = 1'b0;
        bus_addr   = '0;
        bus_be     = 4'h0;
        bus_wdata  = 32'h0;
        case (state)
            ST_IDLE: begin
                if (access) begin
                    stallM     = 1'b1;
                    state_next = bad ? ST_DONE : ST_REQ0;
                end
            end
            ST_REQ0: begin
                stallM    = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = addr_q[31:2];
                bus_be    = mask[3:0];
                bus_wdata = store_lanes[31:0];
                if (bus_gnt) state_next = ST_WAIT0;
            end
            ST_WAIT0: begin
                stallM = 1'b1;
                if (bus_rvalid) state_next = crosses ? ST_REQ1 : ST_DONE;
            end
            ST_REQ1: begin
                stallM    = 1'b1;
                bus_req   = 1'b1;
                bus_we    = we_q;
                bus_addr  = addr_q[31:2] + 30'd1;
                bus_be    = mask[7:4];
                bus_wdata = store_lanes[63:32];
                if (bus_gnt) state_next = ST_WAIT1;
            end
            ST_WAIT1: begin
                stallM = 1'b1;
                if (bus_rvalid) state_next = ST_DONE;
            end
            ST_DONE: begin
                done       = 1'b1;
                err        = err_q;
                readdataM  = (err_q || we_q) ? 32'h0 : load_data;
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb/tb_lsu_mem_ctrl.sv - self-checking bench for lsu_mem_ctrl
module tb_lsu_mem_ctrl;
    import lsu_mem_ctrl_pkg::*;

    logic        clk, reset, reset_b;
    logic        memreadM, memwriteM;
    logic [31:0] aluoutM, writedataM;
    logic [2:0]  memsizeM;
    logic [31:0] readdataM;
    logic        stallM, done, err, bus_req, bus_we;
    logic [29:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_gnt, bus_rvalid;
    logic [31:0] bus_rdata;

    logic [31:0] b_readdataM;
    logic        b_stallM, b_done, b_err, b_bus_req, b_bus_we;
    logic [29:0] b_bus_addr;
    logic [3:0]  b_bus_be;
    logic [31:0] b_bus_wdata;
    logic        b_gnt, b_rvalid;
    logic [31:0] b_rdata;

    int checks = 0;
    int errors = 0;

    lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b1)) dut (
        .clk(clk), .reset(reset), .memreadM(memreadM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .memsizeM(memsizeM),
        .readdataM(readdataM), .stallM(stallM), .done(done), .err(err),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    lsu_mem_ctrl #(.ALLOW_MISALIGNED(1'b0)) dut_strict (
        .clk(clk), .reset(reset_b), .memreadM(memreadM), .memwriteM(memwriteM),
        .aluoutM(aluoutM), .writedataM(writedataM), .memsizeM(memsizeM),
        .readdataM(b_readdataM), .stallM(b_stallM), .done(b_done), .err(b_err),
        .bus_req(b_bus_req), .bus_we(b_bus_we), .bus_addr(b_bus_addr), .bus_be(b_bus_be),
        .bus_wdata(b_bus_wdata), .bus_gnt(b_gnt), .bus_rvalid(b_rvalid), .bus_rdata(b_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Bus-side word memory and an independent byte-level reference memory.
    logic [31:0] bmem [logic [29:0]];
    logic [7:0]  rmem [logic [31:0]];

    function automatic logic [31:0] def_word(input logic [29:0] w);
        return ({w, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A1234;
    endfunction

    function automatic logic [31:0] bus_read(input logic [29:0] w);
        return bmem.exists(w) ? bmem[w] : def_word(w);
    endfunction

    function automatic logic [7:0] ref_byte(input logic [31:0] a);
        logic [31:0] w;
        if (rmem.exists(a)) return rmem[a];
        w = def_word(a[31:2]) >> (8 * a[1:0]);
        return w[7:0];
    endfunction

    function automatic int size_bytes(input logic [2:0] s);
        case (s)
            MEM_B, MEM_BU: return 1;
            MEM_H, MEM_HU: return 2;
            MEM_W:         return 4;
            default:       return 0;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] s);
        logic [31:0] v;
        v = 32'h0;
        for (int i = 0; i < size_bytes(s); i++) v = v | (32'(ref_byte(a + 32'(i))) << (8 * i));
        if (s == MEM_B && v[7])  v = v | 32'hFFFFFF00;
        if (s == MEM_H && v[15]) v = v | 32'hFFFF0000;
        return v;
    endfunction

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [2:0] s);
        logic [31:0] d;
        d = wd;
        for (int i = 0; i < size_bytes(s); i++) begin
            rmem[a + 32'(i)] = d[7:0];
            d = d >> 8;
        end
    endtask

    task automatic preload(input logic [29:0] w, input logic [31:0] d);
        bmem[w] = d;
        for (int i = 0; i < 4; i++) rmem[{w, 2'(i)}] = d[8*i +: 8];
    endtask

    int          res_lat, res_stall, res_nbeats, res_unstable;
    logic [31:0] res_rdata;
    logic        res_err, res_done_after;
    logic [29:0] bt_a  [2];
    logic [3:0]  bt_be [2];
    logic [31:0] bt_wd [2];

    // Presents one access in an IDLE cycle, plays the bus slave, and returns one cycle after done.
    task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] wd, input logic [2:0] sz, input int gdly, input int rdly);
        int          wcnt, rcnt;
        bit          rv_pend, in_beat;
        logic [29:0] h_addr;
        logic [3:0]  h_be;
        logic [31:0] h_wd, rword;
        res_lat = -1; res_stall = 0; res_nbeats = 0; res_unstable = 0;
        res_rdata = 32'h0; res_err = 1'b0;
        memreadM = rd; memwriteM = wr; aluoutM = a; writedataM = wd; memsizeM = sz;
        wcnt = gdly; rcnt = 0; rv_pend = 0; in_beat = 0;
        h_addr = '0; h_be = '0; h_wd = '0; rword = '0;
        #1;
        if (stallM) res_stall++;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            @(posedge clk); #1;
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (done) begin
                res_lat = cyc; res_rdata = readdataM; res_err = err;
                break;
            end
            if (stallM) res_stall++;
            memreadM   = 1'($urandom_range(0, 1));
            memwriteM  = ~memreadM & 1'($urandom_range(0, 1));
            aluoutM    = $urandom;
            writedataM = $urandom;
            memsizeM   = 3'($urandom_range(0, 7));
            if (bus_req) begin
                if (!in_beat) begin
                    in_beat = 1; h_addr = bus_addr; h_be = bus_be; h_wd = bus_wdata;
                end else if (bus_addr != h_addr || bus_be != h_be || bus_wdata != h_wd) begin
                    res_unstable++;
                end
                if (wcnt == 0) begin
                    bus_gnt = 1'b1; in_beat = 0; wcnt = gdly;
                    if (res_nbeats < 2) begin
                        bt_a[res_nbeats] = bus_addr; bt_be[res_nbeats] = bus_be; bt_wd[res_nbeats] = bus_wdata;
                    end
                    res_nbeats++;
                    rword = bus_read(bus_addr);
                    if (bus_we) begin
                        for (int i = 0; i < 4; i++)
                            if (bus_be[i]) rword[8*i +: 8] = bus_wdata[8*i +: 8];
                        bmem[bus_addr] = rword;
                    end
                    rv_pend = 1; rcnt = rdly;
                end else begin
                    wcnt--;
                end
            end else if (rv_pend) begin
                if (rcnt == 0) begin
                    bus_rvalid = 1'b1; bus_rdata = rword; rv_pend = 0;
                end else begin
                    rcnt--;
                end
            end
        end
        memreadM = 1'b0; memwriteM = 1'b0; aluoutM = 32'h0; writedataM = 32'h0; memsizeM = 3'h0;
        @(posedge clk); #1;
        res_done_after = done | stallM;
    endtask

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wd;
        logic [2:0]  size;
        int          gdly, rdly;
        logic [29:0] p0a, p1a;
        logic [31:0] p0d, p1d;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat, exp_beats;
        logic [29:0] b0a, b1a;
        logic [3:0]  b0be, b1be;
        logic [31:0] b0wd, b1wd;
    } vec_t;

    vec_t tvq[$];

    task automatic add(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] sz, input int g, input int r,
                       input logic [29:0] p0a, input logic [31:0] p0d, input logic [29:0] p1a, input logic [31:0] p1d,
                       input logic [31:0] er, input logic ee, input int el, input int eb,
                       input logic [29:0] b0a, input logic [3:0] b0be, input logic [31:0] b0wd,
                       input logic [29:0] b1a, input logic [3:0] b1be, input logic [31:0] b1wd);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.size = sz; v.gdly = g; v.rdly = r;
        v.p0a = p0a; v.p0d = p0d; v.p1a = p1a; v.p1d = p1d;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_beats = eb;
        v.b0a = b0a; v.b0be = b0be; v.b0wd = b0wd; v.b1a = b1a; v.b1be = b1be; v.b1wd = b1wd;
        tvq.push_back(v);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdata"}, readdataM, 32'h0);
        chk({tag, "_ctl"}, 32'({stallM, done, err, bus_req, bus_we, bus_be}), 32'h0);
        chk({tag, "_addr"}, 32'(bus_addr), 32'h0);
        chk({tag, "_wdata"}, bus_wdata, 32'h0);
    endtask

    initial begin
        int          done_cyc, done_seen;
        logic        req_seen, b_err_s;
        logic [31:0] b_rd_s, exp_rd;
        logic        rd, wr, exp_err;
        logic [31:0] a, wd;
        logic [2:0]  sz;
        int          g, r, n, exp_lat;
        logic [2:0]  sizes [8];

        reset = 1'b0; reset_b = 1'b0;
        memreadM = 0; memwriteM = 0; aluoutM = 0; writedataM = 0; memsizeM = 0;
        bus_gnt = 0; bus_rvalid = 0; bus_rdata = 0;
        b_gnt = 0; b_rvalid = 0; b_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_a");
        chk("reset_b_rdata", b_readdataM, 32'h0);
        chk("reset_b_ctl", 32'({b_stallM, b_done, b_err, b_bus_req, b_bus_we, b_bus_be}), 32'h0);
        chk("reset_b_bus", 32'(b_bus_addr) | b_bus_wdata, 32'h0);

        // Strict instance: word-crossing halfword reports an error with no bus traffic.
        reset_b = 1'b1;
        @(posedge clk); #1;
        memreadM = 1; aluoutM = 32'hFFFFFFFF; memsizeM = MEM_H;
        #1;
        chk("strict_stall_t0", 32'(b_stallM), 32'h1);
        done_cyc = -1; req_seen = 0; b_err_s = 0; b_rd_s = 32'hFFFF_FFFF;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(posedge clk); #1;
            memreadM = 0; aluoutM = 0; memsizeM = 0;
            if (b_bus_req) req_seen = 1;
            if (b_done && done_cyc < 0) begin
                done_cyc = cyc; b_err_s = b_err; b_rd_s = b_readdataM;
            end
        end
        chk("strict_done_cycle", 32'(done_cyc), 32'h1);
        chk("strict_err", 32'(b_err_s), 32'h1);
        chk("strict_rdata", b_rd_s, 32'h0);
        chk("strict_no_req", 32'(req_seen), 32'h0);
        reset_b = 1'b0;

        reset = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("post_reset_a");

        //   rd wr addr         wd            size   g r  p0a           p0d           p1a       p1d           rdata         err lat beats b0a           be    wd            b1a       be    wd
        add(1, 0, 32'h100,      32'h0,        MEM_W, 0, 0, 30'h40,      32'hDEADBEEF, 30'h1000, 32'h0,        32'hDEADBEEF, 0, 3, 1, 30'h40,       4'hF, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h103,      32'h0,        MEM_B, 0, 0, 30'h40,      32'h80112233, 30'h1000, 32'h0,        32'hFFFFFF80, 0, 3, 1, 30'h40,       4'h8, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h103,      32'h0,        MEM_BU,0, 0, 30'h40,      32'h80112233, 30'h1000, 32'h0,        32'h00000080, 0, 3, 1, 30'h40,       4'h8, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h100,      32'h0,        MEM_H, 0, 0, 30'h40,      32'h80112233, 30'h1000, 32'h0,        32'h00002233, 0, 3, 1, 30'h40,       4'h3, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h102,      32'h0,        MEM_HU,0, 1, 30'h40,      32'h80112233, 30'h1000, 32'h0,        32'h00008011, 0, 4, 1, 30'h40,       4'hC, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h102,      32'h0,        MEM_H, 1, 0, 30'h40,      32'h80112233, 30'h1000, 32'h0,        32'hFFFF8011, 0, 4, 1, 30'h40,       4'hC, 32'h0,        30'h0,    4'h0, 32'h0);
        add(0, 1, 32'h206,      32'h11223344, MEM_W, 0, 0, 30'h81,      32'h0,        30'h82,   32'h0,        32'h0,        0, 5, 2, 30'h81,       4'hC, 32'h33440000, 30'h82,   4'h3, 32'h00001122);
        add(1, 0, 32'hFFFFFFFF, 32'h0,        MEM_H, 0, 0, 30'h3FFFFFFF,32'hAB000000, 30'h0,    32'h000000CD, 32'hFFFFCDAB, 0, 5, 2, 30'h3FFFFFFF, 4'h8, 32'h0,        30'h0,    4'h1, 32'h0);
        add(1, 0, 32'h100,      32'h0,        3'b011,0, 0, 30'h40,      32'h12345678, 30'h1000, 32'h0,        32'h0,        1, 1, 0, 30'h0,        4'h0, 32'h0,        30'h0,    4'h0, 32'h0);
        add(0, 1, 32'h104,      32'h55,       3'b110,0, 0, 30'h41,      32'h0,        30'h1000, 32'h0,        32'h0,        1, 1, 0, 30'h0,        4'h0, 32'h0,        30'h0,    4'h0, 32'h0);
        add(1, 0, 32'h300,      32'h0,        MEM_W, 4, 0, 30'hC0,      32'hCAFEF00D, 30'h1000, 32'h0,        32'hCAFEF00D, 0, 7, 1, 30'hC0,       4'hF, 32'h0,        30'h0,    4'h0, 32'h0);
        add(0, 1, 32'h101,      32'h000000A5, MEM_B, 1, 2, 30'h40,      32'h0,        30'h1000, 32'h0,        32'h0,        0, 6, 1, 30'h40,       4'h2, 32'h0000A500, 30'h0,    4'h0, 32'h0);

        foreach (tvq[i]) begin
            preload(tvq[i].p0a, tvq[i].p0d);
            preload(tvq[i].p1a, tvq[i].p1d);
            do_access(tvq[i].rd, tvq[i].wr, tvq[i].addr, tvq[i].wd, tvq[i].size, tvq[i].gdly, tvq[i].rdly);
            chk($sformatf("vec%0d_rdata", i), res_rdata, tvq[i].exp_rdata);
            chk($sformatf("vec%0d_err", i), 32'(res_err), 32'(tvq[i].exp_err));
            chk($sformatf("vec%0d_latency", i), 32'(res_lat), 32'(tvq[i].exp_lat));
            chk($sformatf("vec%0d_stall_cycles", i), 32'(res_stall), 32'(tvq[i].exp_lat));
            chk($sformatf("vec%0d_beats", i), 32'(res_nbeats), 32'(tvq[i].exp_beats));
            chk($sformatf("vec%0d_bus_stable", i), 32'(res_unstable), 32'h0);
            chk($sformatf("vec%0d_idle_after", i), 32'(res_done_after), 32'h0);
            if (tvq[i].exp_beats >= 1 && res_nbeats >= 1) begin
                chk($sformatf("vec%0d_b0_addr", i), 32'(bt_a[0]), 32'(tvq[i].b0a));
                chk($sformatf("vec%0d_b0_be", i), 32'(bt_be[0]), 32'(tvq[i].b0be));
                chk($sformatf("vec%0d_b0_wdata", i), bt_wd[0], tvq[i].b0wd);
            end
            if (tvq[i].exp_beats >= 2 && res_nbeats >= 2) begin
                chk($sformatf("vec%0d_b1_addr", i), 32'(bt_a[1]), 32'(tvq[i].b1a));
                chk($sformatf("vec%0d_b1_be", i), 32'(bt_be[1]), 32'(tvq[i].b1be));
                chk($sformatf("vec%0d_b1_wdata", i), bt_wd[1], tvq[i].b1wd);
            end
        end

        sizes = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU, MEM_W, MEM_H, 3'b011};
        for (int it = 0; it < 200; it++) begin
            rd = 1'($urandom_range(0, 1));
            wr = ~rd;
            sz = sizes[$urandom_range(0, 7)];
            if ($urandom_range(0, 19) == 0) sz = 3'b111;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            else a = 32'($urandom_range(0, 63));
            wd = $urandom;
            g = $urandom_range(0, 3);
            r = $urandom_range(0, 3);
            n = size_bytes(sz);
            exp_err = (n == 0);
            exp_rd  = 32'h0;
            if (exp_err) begin
                exp_lat = 1;
            end else begin
                exp_lat = ((int'(a[1:0]) + n > 4) ? 2 : 1) * (2 + g + r) + 1;
                if (rd) exp_rd = ref_load(a, sz);
                else ref_store(a, wd, sz);
            end
            do_access(rd, wr, a, wd, sz, g, r);
            chk($sformatf("rand%0d_rdata a=%08h sz=%0d", it, a, sz), res_rdata, exp_rd);
            chk($sformatf("rand%0d_err", it), 32'(res_err), 32'(exp_err));
            chk($sformatf("rand%0d_latency", it), 32'(res_lat), 32'(exp_lat));
            chk($sformatf("rand%0d_stall_cycles", it), 32'(res_stall), 32'(exp_lat));
            chk($sformatf("rand%0d_idle_after", it), 32'(res_done_after), 32'h0);
        end

        // Reset while waiting for the read response, followed by a stray response.
        memreadM = 1; aluoutM = 32'h100; memsizeM = MEM_W;
        @(posedge clk); #1;
        memreadM = 0; aluoutM = 0; memsizeM = 0;
        chk("abort_req", 32'(bus_req), 32'h1);
        bus_gnt = 1;
        @(posedge clk); #1;
        bus_gnt = 0;
        chk("abort_wait_stall", 32'(stallM), 32'h1);
        reset = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        chk("abort_stall", 32'(stallM), 32'h0);
        chk("abort_done", 32'(done), 32'h0);
        chk("abort_req_off", 32'(bus_req), 32'h0);
        bus_rvalid = 1; bus_rdata = 32'h13572468;
        @(posedge clk); #1;
        bus_rvalid = 0;
        done_seen = 0;
        for (int cyc = 0; cyc < 4; cyc++) begin
            if (done || stallM) done_seen++;
            @(posedge clk); #1;
        end
        chk("stray_rvalid_no_done", 32'(done_seen), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
